alu_seq_ctrl: RTL

- Accumulator-style sequencer that issues commands to the external 32-bit combinational ALU: drives alu_a/alu_b/alu_op and captures alu_out.
- Sits between a command source (valid/ready) and a response sink (valid/ready).
- Holds a 32-bit accumulator and a completed-command counter.
- Opcode encoding matches the ALU: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOR=6.

---
 rtl/alu_seq_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Accumulator sequencer: takes one command at a time, drives the external ALU for a single
// EXEC cycle, folds the result into the accumulator and holds a response until it is taken.
module alu_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int MAX_OP = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [1:0]        cmd_mode,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] acc,
    output logic [CNT_W-1:0]  cmd_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] MODE_IMM_ACC = 2'b01;
    localparam logic [1:0] MODE_LOAD    = 2'b10;
    localparam logic [1:0] MODE_ACC_ACC = 2'b11;

    logic [1:0]        r_state;
    logic [OP_W-1:0]   r_op;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_illegal;
    logic              w_load;
    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [OP_W-1:0]   w_alu_op;
    logic [DATA_W-1:0] w_acc_next;

    assign w_load    = (r_mode == MODE_LOAD);
    assign w_illegal = !w_load && (r_op > OP_W'(MAX_OP));

    // ALU is only ever driven during EXEC; LOAD and illegal opcodes present op 0.
    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = '0;
        if (r_state == ST_EXEC && !w_load) begin
            case (r_mode)
                MODE_IMM_ACC: begin w_alu_a = r_imm; w_alu_b = r_acc; end
                MODE_ACC_ACC: begin w_alu_a = r_acc; w_alu_b = r_acc; end
                default:      begin w_alu_a = r_acc; w_alu_b = r_imm; end
            endcase
            w_alu_op = w_illegal ? '0 : r_op;
        end
    end

    always_comb begin
        w_acc_next = r_acc;
        if (w_load)
            w_acc_next = r_imm;
        else if (!w_illegal && r_op != '0)
            w_acc_next = alu_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_mode     <= '0;
            r_imm      <= '0;
            r_acc      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_mode  <= cmd_mode;
                        r_imm   <= cmd_imm;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_acc      <= w_acc_next;
                    r_rsp_data <= w_acc_next;
                    r_rsp_err  <= w_illegal;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        if (r_cnt != '1)
                            r_cnt <= r_cnt + 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign acc       = r_acc;
    assign cmd_cnt   = r_cnt;
    assign alu_a     = w_alu_a;
    assign alu_b     = w_alu_b;
    assign alu_op    = w_alu_op;

endmodule
